// File: rtl/fwrisc_regfile_ctrl_pkg.sv
// Shared types for the fwrisc register-file controller: FSM states and the GPR/CSR split.
// Combinational helper only; no latency or backpressure of its own.
package fwrisc_regfile_ctrl_pkg;

    typedef enum logic [1:0] {
        CLEAR   = 2'd0,
        RUN     = 2'd1,
        DBG_RD  = 2'd2,
        DBG_ACK = 2'd3
    } regfile_ctrl_state_e;

    localparam int unsigned REGFILE_CSR_BASE = 32;

    // x0 is hardwired; CSR-space writes from debug only when the build allows them.
    function automatic logic dbg_write_allowed(input logic [5:0] addr, input logic csr_write_en);
        return (addr != 6'd0) && ((addr < 6'(REGFILE_CSR_BASE)) || csr_write_en);
    endfunction

endpackage

// File: rtl/fwrisc_regfile_clear_seq.sv
// Clear counter for GPR zeroing: walks 1..CLEAR_LAST one index per active cycle.
// Restart (reset or soft reset) returns to index 1 on the next cycle; no backpressure.
module fwrisc_regfile_clear_seq #(
    parameter int unsigned CLEAR_LAST = 31
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       restart_i,
    input  logic       active_i,
    output logic [5:0] clear_idx_o,
    output logic       clear_done_o
);

    logic [5:0] clear_idx_q;
    logic [5:0] clear_idx_d;

    assign clear_idx_o  = clear_idx_q;
    assign clear_done_o = (clear_idx_q == 6'(CLEAR_LAST));

    always_comb begin
        clear_idx_d = clear_idx_q;
        if (restart_i || (active_i && clear_done_o)) begin
            clear_idx_d = 6'd1;
        end else if (active_i) begin
            clear_idx_d = clear_idx_q + 6'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            clear_idx_q <= 6'd1;
        end else begin
            clear_idx_q <= clear_idx_d;
        end
    end

endmodule

// File: rtl/fwrisc_regfile_ctrl.sv
// Register-file port owner: GPR clear sequencer (FWRISC_REGFILE_CLEAR_EN) plus debug/core arbitration.
// Debug write acks 1 cycle after grant, read 2 cycles; core writeback always wins and debug stalls the core.
module fwrisc_regfile_ctrl
    import fwrisc_regfile_ctrl_pkg::*;
#(
    parameter int          DBG_CSR_WRITE = 0,
    parameter int unsigned CLEAR_LAST    = 31
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        soft_reset_req,
    input  logic [5:0]  core_ra_raddr,
    input  logic [5:0]  core_rb_raddr,
    input  logic [5:0]  core_rd_waddr,
    input  logic [31:0] core_rd_wdata,
    input  logic        core_rd_wen,
    output logic        core_stall,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [5:0]  dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [31:0] dbg_rdata,
    output logic [5:0]  ra_raddr,
    output logic [5:0]  rb_raddr,
    output logic [5:0]  rd_waddr,
    output logic [31:0] rd_wdata,
    output logic        rd_wen,
    input  logic [31:0] rb_rdata
);

    regfile_ctrl_state_e state_q, state_d;
    logic                dbg_ack_q, dbg_ack_d;
    logic [31:0]         dbg_rdata_q, dbg_rdata_d;
    logic                soft_rst;
    logic                clear_fin;
    logic                grant, wr_grant, rd_grant;

`ifdef FWRISC_REGFILE_CLEAR_EN
    localparam regfile_ctrl_state_e RESET_STATE = CLEAR;
    logic [5:0] clear_idx;

    assign soft_rst = soft_reset_req;

    fwrisc_regfile_clear_seq #(
        .CLEAR_LAST (CLEAR_LAST)
    ) u_clear_seq (
        .clock        (clock),
        .reset        (reset),
        .restart_i    (soft_reset_req),
        .active_i     (state_q == CLEAR),
        .clear_idx_o  (clear_idx),
        .clear_done_o (clear_fin)
    );
`else
    localparam regfile_ctrl_state_e RESET_STATE = RUN;
    localparam int unsigned UNUSED_CLEAR_LAST = CLEAR_LAST;
    logic unused_soft_reset_req;

    assign unused_soft_reset_req = soft_reset_req;
    assign soft_rst              = 1'b0;
    assign clear_fin             = 1'b1;
`endif

    // A soft reset in the same cycle as a request suppresses the grant entirely.
    assign grant    = (state_q == RUN) && dbg_req && !core_rd_wen && !soft_rst;
    assign wr_grant = grant && dbg_we;
    assign rd_grant = grant && !dbg_we;

    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR:   state_d = clear_fin ? RUN : CLEAR;
            RUN:     if (grant) state_d = dbg_we ? DBG_ACK : DBG_RD;
            DBG_RD:  state_d = DBG_ACK;
            DBG_ACK: state_d = RUN;
            default: state_d = RESET_STATE;
        endcase
        if (soft_rst) begin
            state_d = CLEAR;
        end
    end

    assign dbg_ack_d   = (state_d == DBG_ACK);
    assign dbg_rdata_d = (state_q == DBG_RD) ? rb_rdata : dbg_rdata_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RESET_STATE;
            dbg_ack_q   <= 1'b0;
            dbg_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            dbg_ack_q   <= dbg_ack_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign dbg_ack    = dbg_ack_q;
    assign dbg_rdata  = dbg_rdata_q;
    assign core_stall = (state_q == CLEAR) || (state_q == DBG_RD) || grant;
    assign ra_raddr   = core_ra_raddr;
    assign rb_raddr   = rd_grant ? dbg_addr : core_rb_raddr;

    always_comb begin
        rd_waddr = core_rd_waddr;
        rd_wdata = core_rd_wdata;
        rd_wen   = core_rd_wen;
`ifdef FWRISC_REGFILE_CLEAR_EN
        if (state_q == CLEAR) begin
            rd_waddr = clear_idx;
            rd_wdata = 32'h0;
            rd_wen   = 1'b1;
        end else
`endif
        if (wr_grant) begin
            rd_waddr = dbg_addr;
            rd_wdata = dbg_wdata;
            rd_wen   = dbg_write_allowed(dbg_addr, DBG_CSR_WRITE != 0);
        end
        if (reset) begin
            rd_wen = 1'b0;
        end
    end

endmodule

// File: tb/tb_fwrisc_regfile_ctrl.sv
// Scoreboard bench for fwrisc_regfile_ctrl: expected regfile writes and debug acks are queued
// with their cycle stamps by the stimulus and popped by a negedge monitor.
module tb_fwrisc_regfile_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        soft_reset_req;
    logic [5:0]  core_ra_raddr, core_rb_raddr, core_rd_waddr;
    logic [31:0] core_rd_wdata;
    logic        core_rd_wen;
    logic        core_stall;
    logic        dbg_req, dbg_we;
    logic [5:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic [5:0]  ra_raddr, rb_raddr, rd_waddr;
    logic [31:0] rd_wdata;
    logic        rd_wen;
    logic [31:0] rb_rdata;

    fwrisc_regfile_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .soft_reset_req (soft_reset_req),
        .core_ra_raddr  (core_ra_raddr),
        .core_rb_raddr  (core_rb_raddr),
        .core_rd_waddr  (core_rd_waddr),
        .core_rd_wdata  (core_rd_wdata),
        .core_rd_wen    (core_rd_wen),
        .core_stall     (core_stall),
        .dbg_req        (dbg_req),
        .dbg_we         (dbg_we),
        .dbg_addr       (dbg_addr),
        .dbg_wdata      (dbg_wdata),
        .dbg_ack        (dbg_ack),
        .dbg_rdata      (dbg_rdata),
        .ra_raddr       (ra_raddr),
        .rb_raddr       (rb_raddr),
        .rd_waddr       (rd_waddr),
        .rd_wdata       (rd_wdata),
        .rd_wen         (rd_wen),
        .rb_rdata       (rb_rdata)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural register file: synchronous write, read data one cycle after address.
    logic [31:0] mem [64];
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        end else if (rd_wen) begin
            mem[rd_waddr] <= rd_wdata;
        end
        rb_rdata <= mem[rb_raddr];
    end

    typedef struct {
        int          cyc;
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_exp_t;

    typedef struct {
        int          cyc;
        bit          chk_data;
        logic [31:0] data;
    } ack_exp_t;

    wr_exp_t  wr_q[$];
    ack_exp_t ack_q[$];
    wr_exp_t  mon_wr;
    ack_exp_t mon_ack;

    always @(negedge clock) begin
        if (rd_wen === 1'b1) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write cycle=%0d addr=%0d data=%h, required no write", cyc, rd_waddr, rd_wdata);
            end else begin
                mon_wr = wr_q.pop_front();
                if (cyc != mon_wr.cyc || rd_waddr !== mon_wr.addr || rd_wdata !== mon_wr.data) begin
                    errors++;
                    $display("FAIL regfile_write actual cycle=%0d addr=%0d data=%h required cycle=%0d addr=%0d data=%h",
                             cyc, rd_waddr, rd_wdata, mon_wr.cyc, mon_wr.addr, mon_wr.data);
                end
            end
        end
        if (dbg_ack === 1'b1) begin
            checks++;
            if (ack_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_dbg_ack cycle=%0d rdata=%h, required no ack", cyc, dbg_rdata);
            end else begin
                mon_ack = ack_q.pop_front();
                if (cyc != mon_ack.cyc || (mon_ack.chk_data && dbg_rdata !== mon_ack.data)) begin
                    errors++;
                    $display("FAIL dbg_ack actual cycle=%0d rdata=%h required cycle=%0d rdata=%h",
                             cyc, dbg_rdata, mon_ack.cyc, mon_ack.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_wr(input int c, input logic [5:0] a, input logic [31:0] d);
        wr_exp_t e;
        e.cyc = c; e.addr = a; e.data = d;
        wr_q.push_back(e);
    endtask

    task automatic push_ack(input int c, input bit chk, input logic [31:0] d);
        ack_exp_t e;
        e.cyc = c; e.chk_data = chk; e.data = d;
        ack_q.push_back(e);
    endtask

    // One debug transaction with the core idle; grant is expected in the first cycle.
    task automatic dbg_op(input bit we, input logic [5:0] a, input logic [31:0] d,
                          input bit wr_expected, input logic [31:0] rd_exp);
        int g;
        tick();
        g = cyc;
        dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
        if (we) begin
            if (wr_expected) push_wr(g, a, d);
            push_ack(g + 1, 1'b0, 32'h0);
        end else begin
            push_ack(g + 2, 1'b1, rd_exp);
        end
        #3 check("grant_stall", 32'(core_stall), 32'd1);
        if (!we) check("rb_raddr_dbg", 32'(rb_raddr), 32'(a));
        tick();
        if (!we) begin
            #3 check("dbg_rd_stall", 32'(core_stall), 32'd1);
            tick();
        end
        #3 check("ack_cycle_stall", 32'(core_stall), 32'd0);
        tick();
        dbg_req = 1'b0; dbg_we = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycle=%0d, required completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        reset = 1'b1; soft_reset_req = 1'b0;
        core_ra_raddr = '0; core_rb_raddr = '0; core_rd_waddr = '0;
        core_rd_wdata = '0; core_rd_wen = 1'b0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

        repeat (3) tick();
        #3;
        check("reset_dbg_ack", 32'(dbg_ack), 32'd0);
        check("reset_dbg_rdata", dbg_rdata, 32'h0);
        check("reset_rd_wen", 32'(rd_wen), 32'd0);
`ifdef FWRISC_REGFILE_CLEAR_EN
        check("reset_core_stall", 32'(core_stall), 32'd1);
`else
        check("reset_core_stall", 32'(core_stall), 32'd0);
`endif
        tick();
        reset = 1'b0;
        g = cyc;
`ifdef FWRISC_REGFILE_CLEAR_EN
        for (int i = 0; i < 31; i++) push_wr(g + i, 6'(i + 1), 32'h0);
        #3 check("clear_first_stall", 32'(core_stall), 32'd1);
        repeat (30) tick();
        #3 check("clear_last_stall", 32'(core_stall), 32'd1);
        tick();
        #3 check("first_run_stall", 32'(core_stall), 32'd0);
`else
        #3 check("first_cycle_stall", 32'(core_stall), 32'd0);
`endif

        // Read ports pass straight through from the core while idle.
        tick();
        core_ra_raddr = 6'd3; core_rb_raddr = 6'd4;
        #3;
        check("ra_passthrough", 32'(ra_raddr), 32'd3);
        check("rb_passthrough", 32'(rb_raddr), 32'd4);

        dbg_op(1'b1, 6'd5, 32'hDEAD_BEEF, 1'b1, 32'h0);
        dbg_op(1'b0, 6'd5, 32'h0, 1'b0, 32'hDEAD_BEEF);

        // Core writeback holds off a pending debug write for three cycles.
        tick();
        g = cyc;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 6'd10; dbg_wdata = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            core_rd_wen = 1'b1;
            core_rd_waddr = 6'(7 + i);
            core_rd_wdata = 32'hA000_0000 + 32'(i);
            push_wr(g + i, 6'(7 + i), 32'hA000_0000 + 32'(i));
            #3 check("core_wb_no_stall", 32'(core_stall), 32'd0);
            tick();
        end
        core_rd_wen = 1'b0;
        push_wr(g + 3, 6'd10, 32'h1234_5678);
        push_ack(g + 4, 1'b0, 32'h0);
        #3 check("deferred_grant_stall", 32'(core_stall), 32'd1);
        tick();
        tick();
        dbg_req = 1'b0; dbg_we = 1'b0;

        dbg_op(1'b1, 6'd40, 32'hCAFE_F00D, 1'b0, 32'h0);
        dbg_op(1'b1, 6'd0, 32'h5555_AAAA, 1'b0, 32'h0);
        dbg_op(1'b0, 6'd40, 32'h0, 1'b0, 32'h0);
        dbg_op(1'b0, 6'd8, 32'h0, 1'b0, 32'hA000_0001);
        dbg_op(1'b0, 6'd10, 32'h0, 1'b0, 32'h1234_5678);

        // Soft reset arriving while a debug read sits in DBG_RD.
        tick();
        g = cyc;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd7;
`ifdef FWRISC_REGFILE_CLEAR_EN
        tick();
        soft_reset_req = 1'b1;
        for (int i = 0; i < 31; i++) push_wr(g + 2 + i, 6'(i + 1), 32'h0);
        push_ack(g + 35, 1'b1, 32'h0);
        tick();
        soft_reset_req = 1'b0;
        #3 check("soft_clear_stall", 32'(core_stall), 32'd1);
        repeat (34) tick();
        dbg_req = 1'b0;
`else
        push_ack(g + 2, 1'b1, 32'hA000_0000);
        tick();
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        #3 check("soft_ignored_ack_stall", 32'(core_stall), 32'd0);
        tick();
        dbg_req = 1'b0;
        soft_reset_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #3 check("idle_soft_reset_stall", 32'(core_stall), 32'd0);
            tick();
        end
        soft_reset_req = 1'b0;
`endif

        repeat (4) tick();
        check("write_queue_drained", 32'(wr_q.size()), 32'd0);
        check("ack_queue_drained", 32'(ack_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwrisc_regfile_ctrl.md
# fwrisc_regfile_ctrl

Sits between the fwrisc core and `fwrisc_regfile` and owns the register-file ports. After reset or a soft reset it zeroes GPRs x1..x31 with a clear sequencer. It also arbitrates the write port and read port B between core writeback and a debug access port, stalling the core when debug takes the port.

## Interface
Parameters:
- `DBG_CSR_WRITE`, 0: 1 lets debug write addresses 32..63; 0 suppresses the write but still acknowledges it.
- `CLEAR_LAST`, 31: last GPR index cleared by the sequencer.

Ports:
- `clock` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `soft_reset_req` in 1: from regfile; core wrote CSR_SOFT_RESET.
- `core_ra_raddr`, `core_rb_raddr` in 6: core read addresses.
- `core_rd_waddr` in 6, `core_rd_wdata` in 32, `core_rd_wen` in 1: core writeback.
- `core_stall` out 1: core must hold its state this cycle.
- `dbg_req` in 1, `dbg_we` in 1, `dbg_addr` in 6, `dbg_wdata` in 32: debug request.
- `dbg_ack` out 1: one-cycle completion pulse.
- `dbg_rdata` out 32: debug read data; valid with `dbg_ack`.
- `ra_raddr`, `rb_raddr` out 6: to regfile.
- `rd_waddr` out 6, `rd_wdata` out 32, `rd_wen` out 1: to regfile.
- `rb_rdata` in 32: from regfile; valid 1 cycle after `rb_raddr`.

## Operation
FSM states: CLEAR, RUN, DBG_RD, DBG_ACK.

- **CLEAR:** each cycle drives `rd_wen`=1, `rd_waddr`=`clear_idx`, `rd_wdata`=0, then increments `clear_idx`. When `clear_idx`==`CLEAR_LAST`, that write completes and the FSM goes to RUN. `core_stall`=1. A pending `dbg_req` is not served.
- **RUN:** core signals pass through to the regfile; `core_stall`=0.
  - Grant when `dbg_req` && !`core_rd_wen`. Core writeback always wins over debug.
  - Write grant: the `rd_*` mux selects debug this cycle and `core_stall`=1. Next state is DBG_ACK.
  - Read grant: `rb_raddr`=`dbg_addr` and `core_stall`=1. Next state is DBG_RD.
- **DBG_RD:** `core_stall`=1; `dbg_rdata` <= `rb_rdata`. Next state is DBG_ACK.
- **DBG_ACK:** `dbg_ack`=1 and `core_stall`=0. No new grant this cycle. Next state is RUN.
- **Write suppression:** debug writes to addr 0 never assert `rd_wen`. Writes to addr 32..63 do not assert `rd_wen` when `DBG_CSR_WRITE`=0. Both are still acknowledged.
- **Requester rule:** hold `dbg_req`, `dbg_we`, `dbg_addr` and `dbg_wdata` stable until `dbg_ack`, then deassert for at least one cycle or present the next request.
- **Soft reset:** `soft_reset_req` in any state sends the FSM to CLEAR next cycle with `clear_idx`=1.
  - An in-flight debug transaction is aborted with no `dbg_ack`.
  - The still-held request is served after CLEAR.

## Timing
- Reset values: state=CLEAR, `clear_idx`=1, `dbg_ack`=0, `dbg_rdata`=0, `core_stall`=1.
- `rd_wen` is forced to 0 while `reset`=1.
- Clear takes `CLEAR_LAST` cycles. The first RUN cycle is `CLEAR_LAST` cycles after `reset` deasserts.
- Debug write: grant in cycle N, `dbg_ack` in N+1.
- Debug read: grant in N, `dbg_ack` and `dbg_rdata` in N+2. Core stalls in N and N+1.
- Regfile-side outputs are combinational from state and inputs. `dbg_ack`, `dbg_rdata` and state are registered.
- Reset mid-clear restarts at `clear_idx`=1.
- `soft_reset_req` and a grant in the same cycle: soft reset wins and no grant occurs.

## Configuration
`FWRISC_REGFILE_CLEAR_EN`:
- Defined: behaviour is as above.
- Undefined: the CLEAR state and `clear_idx` are removed.
  - Reset state is RUN and `core_stall` resets to 0.
  - `soft_reset_req` is ignored; debug transactions are not aborted.

## Structure
- Package `fwrisc_regfile_ctrl_pkg` holds:
  - the state enum `regfile_ctrl_state_e`;
  - the GPR/CSR address boundary constant `REGFILE_CSR_BASE`=32.
- One sub-module, `fwrisc_regfile_clear_seq`, holds the clear counter and the CLEAR-done flag. It is instantiated only under the macro.

## Test plan
- Reset with `CLEAR_LAST`=31: 31 consecutive writes to addresses 1..31 with data 0; `core_stall` drops on cycle 31; addr 0 is never written.
- Debug write of addr 5, data 0xDEADBEEF while the core is idle: `rd_wen`=1 for one cycle, `dbg_ack` the next cycle; a later debug read of 5 returns 0xDEADBEEF with ack 2 cycles after grant.
- `dbg_req` while `core_rd_wen`=1 for 3 cycles: core writes complete, and the grant happens on the first cycle with `core_rd_wen`=0.
- Debug write of addr 40 with `DBG_CSR_WRITE`=0: `rd_wen` stays 0 and `dbg_ack` still pulses.
- `soft_reset_req` in the DBG_RD cycle: no `dbg_ack`, 31 clear writes follow, then the held read is served and acknowledged.
- Macro undefined: `core_stall`=0 from the first cycle after reset, and `soft_reset_req` produces no clear writes.
